// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO for router output-channel buffering, with occupancy count,
// watermarks and overflow/underflow pulses. Define FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned AFULL_THRESH  = 28,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t DepthCnt  = ptr_t'(DEPTH);
    localparam ptr_t AfullCnt  = ptr_t'(AFULL_THRESH);
    localparam ptr_t AemptyCnt = ptr_t'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    ptr_t                  count_q, count_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  overflow_q, underflow_q;

    logic                  wr_ok, rd_ok;
    logic                  full_c, empty_c;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    assign wr_ok = wr_en & ~full_c;
    assign rd_ok = rd_en & ~empty_c;

`ifdef FIFO_FWFT_EN
    // The output register holds the head word; count covers it plus the words still in memory.
    logic valid_q, valid_d;
    logic mem_nonempty, load;

    assign mem_nonempty = (wr_ptr_q != rd_ptr_q);
    assign full_c       = (count_q == DepthCnt);
    assign empty_c      = ~valid_q;
    assign load         = mem_nonempty & (~valid_q | rd_ok);

    always_comb begin
        valid_d  = load | (valid_q & ~rd_ok);
        rd_ptr_d = rd_ptr_q + ptr_t'(load);
        data_d   = load ? mem_q[rd_addr] : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end
`else
    assign full_c  = (wr_addr == rd_addr) && (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);

    always_comb begin
        rd_ptr_d = rd_ptr_q + ptr_t'(rd_ok);
        data_d   = rd_ok ? mem_q[rd_addr] : data_q;
    end
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q + ptr_t'(wr_ok);
        count_d  = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + ptr_t'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - ptr_t'(1);
        end
    end

    // Storage is never cleared; reset only discards it by zeroing the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            overflow_q  <= wr_en & full_c;
            underflow_q <= rd_en & empty_c;
        end
    end

    assign data_out     = data_q;
    assign full         = full_c;
    assign empty        = empty_c;
    assign almost_full  = (count_q >= AfullCnt);
    assign almost_empty = (count_q <= AemptyCnt);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
